// File: rtl/seg_shift_ctrl.sv
// rtl/seg_shift_ctrl.sv - serial 7-segment shift chain sequencer
// Shifts a captured frame MSB-first on a divided seg_clk, then strobes seg_pen.
module seg_shift_ctrl #(
  parameter int NBITS      = 64,
  parameter int DIV        = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] frame,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             seg_clk,
  output logic             seg_dat,
  output logic             seg_pen
);

  localparam int              CW       = $clog2(NBITS);
  localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);
  localparam logic [CW-1:0]   BIT_LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bitcnt, bitcnt_nxt;
  logic [7:0]       div, div_nxt;
  logic             busy_nxt, done_nxt, seg_clk_nxt, seg_dat_nxt, seg_pen_nxt;
  logic [NBITS-1:0] cap;
  logic             div_end;

  assign cap     = ACTIVE_LOW ? ~frame : frame;
  assign div_end = (div == DIV_LAST);
  assign ready   = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      div     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg_clk <= 1'b0;
      seg_dat <= 1'b0;
      seg_pen <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bitcnt  <= bitcnt_nxt;
      div     <= div_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      seg_clk <= seg_clk_nxt;
      seg_dat <= seg_dat_nxt;
      seg_pen <= seg_pen_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bitcnt_nxt  = bitcnt;
    div_nxt     = div;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    seg_clk_nxt = seg_clk;
    seg_dat_nxt = seg_dat;
    seg_pen_nxt = seg_pen;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt   = cap;
          seg_dat_nxt = cap[NBITS-1];
          busy_nxt    = 1'b1;
          div_nxt     = '0;
          bitcnt_nxt  = '0;
          state_nxt   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_end) begin
          div_nxt     = '0;
          seg_clk_nxt = 1'b1;
          state_nxt   = SHIFT_HI;
        end else begin
          div_nxt = div + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_end) begin
          div_nxt     = '0;
          seg_clk_nxt = 1'b0;
          // Data only moves on the falling seg_clk edge, keeping DIV cycles of setup/hold.
          if (bitcnt == BIT_LAST) begin
            seg_pen_nxt = 1'b1;
            state_nxt   = LATCH;
          end else begin
            bitcnt_nxt  = bitcnt + 1'b1;
            shreg_nxt   = shreg << 1;
            seg_dat_nxt = shreg[NBITS-2];
            state_nxt   = SHIFT_LO;
          end
        end else begin
          div_nxt = div + 8'd1;
        end
      end
      LATCH: begin
        if (div_end) begin
          div_nxt     = '0;
          seg_pen_nxt = 1'b0;
          busy_nxt    = 1'b0;
          seg_dat_nxt = 1'b0;
          done_nxt    = 1'b1;
          state_nxt   = IDLE;
        end else begin
          div_nxt = div + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// tb/tb_seg_shift_ctrl.sv - self-checking bench for seg_shift_ctrl
// Default instance runs sequence checks; minimum instance runs a cycle-exact vector table.
module tb_seg_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d = 1'b1, start_d = 1'b0;
  logic [63:0] frame_d = '0;
  logic        ready_d, busy_d, done_d, sclk_d, sdat_d, pen_d;

  logic        rst_m = 1'b1, start_m = 1'b0;
  logic [7:0]  frame_m = '0;
  logic        ready_m, busy_m, done_m, sclk_m, sdat_m, pen_m;

  seg_shift_ctrl u_def (
    .clk(clk), .rst(rst_d), .start(start_d), .frame(frame_d),
    .ready(ready_d), .busy(busy_d), .done(done_d),
    .seg_clk(sclk_d), .seg_dat(sdat_d), .seg_pen(pen_d)
  );

  seg_shift_ctrl #(.NBITS(8), .DIV(1), .ACTIVE_LOW(1'b0)) u_min (
    .clk(clk), .rst(rst_m), .start(start_m), .frame(frame_m),
    .ready(ready_m), .busy(busy_m), .done(done_m),
    .seg_clk(sclk_m), .seg_dat(sdat_m), .seg_pen(pen_m)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {ready, busy, done, seg_clk, seg_dat, seg_pen}
  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] frame;
    logic [5:0] exp;
  } vec_t;
  vec_t tv[$];

  function automatic void add(input logic r, input logic s, input logic [7:0] f, input logic [5:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.frame = f; v.exp = e;
    tv.push_back(v);
  endfunction

  // Outcome of one default-config transfer
  logic [63:0] got_bits;
  int          n_rise, n_busy, n_pen, n_done;
  logic        finished;

  task automatic send_def(input logic [63:0] f);
    logic pclk;
    @(negedge clk);
    start_d = 1'b1; frame_d = f;
    got_bits = '0; n_rise = 0; n_busy = 0; n_pen = 0; n_done = 0; finished = 1'b0; pclk = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      @(negedge clk);
      start_d = 1'b0;
      frame_d = {$urandom, $urandom};
      if (busy_d) n_busy++;
      if (pen_d)  n_pen++;
      if (sclk_d && !pclk) begin
        got_bits = {got_bits[62:0], sdat_d};
        n_rise++;
      end
      pclk = sclk_d;
      if (done_d) begin
        n_done++;
        chk("done_with_ready_idle", {62'd0, ready_d, busy_d}, 64'h2);
        finished = 1'b1;
      end
    end
    chk("transfer_finished", {63'd0, finished}, 64'd1);
  endtask

  logic [7:0] bits_a = 8'b1010_0101;
  logic [7:0] bits_b = 8'b0011_1100;

  initial begin
    // Default-config reset/idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("def_reset", {58'd0, ready_d, busy_d, done_d, sclk_d, sdat_d, pen_d}, 64'h20);
    end
    rst_d = 1'b0;

    send_def(64'h00FF_0000_0000_0001);
    chk("def_bits", got_bits, 64'hFF00_FFFF_FFFF_FFFE);
    chk("def_rises", 64'(n_rise), 64'd64);
    chk("def_busy_cycles", 64'(n_busy), 64'd258);
    chk("def_pen_cycles", 64'(n_pen), 64'd2);
    chk("def_done_pulses", 64'(n_done), 64'd1);
    @(negedge clk);
    chk("def_done_one_cycle", {63'd0, done_d}, 64'd0);

    // Reset after 20 serial bits
    begin
      logic pclk;
      int   rises, bad;
      @(negedge clk);
      start_d = 1'b1; frame_d = 64'h1234_5678_9ABC_DEF0;
      pclk = 1'b0; rises = 0;
      for (int c = 0; c < 200 && rises < 20; c++) begin
        @(negedge clk);
        start_d = 1'b0;
        if (sclk_d && !pclk) rises++;
        pclk = sclk_d;
      end
      chk("mid_rises_reached", 64'(rises), 64'd20);
      rst_d = 1'b1;
      @(negedge clk);
      rst_d = 1'b0;
      chk("mid_reset_outputs", {58'd0, ready_d, busy_d, done_d, sclk_d, sdat_d, pen_d}, 64'h20);
      bad = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (done_d || pen_d || busy_d) bad++;
      end
      chk("mid_no_pulses_after_reset", 64'(bad), 64'd0);
    end

    send_def(64'h00FF_0000_0000_0001);
    chk("post_reset_busy_cycles", 64'(n_busy), 64'd258);
    chk("post_reset_bits", got_bits, 64'hFF00_FFFF_FFFF_FFFE);

    // Minimum config vector table: A5 with start held, then back-to-back 3C
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 8'h00, 6'b100000);
    add(1'b0, 1'b0, 8'h00, 6'b100000);
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b1, (i == 0) ? 8'hA5 : 8'(8'h11 * i), {4'b0100, bits_a[7-i], 1'b0});
      add(1'b0, 1'b1, 8'(8'h5A ^ i),                    {4'b0101, bits_a[7-i], 1'b0});
    end
    add(1'b0, 1'b1, 8'hFF, 6'b010011);
    add(1'b0, 1'b1, 8'hFF, 6'b101000);
    for (int i = 0; i < 8; i++) begin
      add(1'b0, (i == 0), (i == 0) ? 8'h3C : 8'(8'hC3 + i), {4'b0100, bits_b[7-i], 1'b0});
      add(1'b0, 1'b0, 8'(8'h0F * i),                        {4'b0101, bits_b[7-i], 1'b0});
    end
    add(1'b0, 1'b0, 8'hFF, 6'b010001);
    add(1'b0, 1'b0, 8'hFF, 6'b101000);
    add(1'b0, 1'b0, 8'hFF, 6'b100000);

    @(negedge clk);
    foreach (tv[k]) begin
      rst_m = tv[k].rst; start_m = tv[k].start; frame_m = tv[k].frame;
      @(negedge clk);
      chk($sformatf("min_vec%0d", k), {58'd0, ready_m, busy_m, done_m, sclk_m, sdat_m, pen_m},
          {58'd0, tv[k].exp});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_shift_ctrl.md
Name: seg_shift_ctrl

Overview:
- Sequences the serial 7-segment shift chain on the board.
- Accepts one full frame of 8-digit segment patterns (8 bits per digit, already mapped to segment order by the upstream segment mapper) through a start/ready handshake.
- Shifts the frame out MSB-first on a divided serial clock, then pulses the latch strobe.
- Sits between the display mapping logic and the top-level pins; owns all timing of seg_clk/seg_dat/seg_pen.

Parameters:
- NBITS, 64, frame length in bits (8 digits x 8 segments); legal 2..256.
- DIV, 2, clk cycles per serial-clock half period; legal 1..255.
- ACTIVE_LOW, 1, when 1 the frame is bitwise inverted on capture (segments lit by 0).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to send frame; sampled only when ready=1.
- frame  input  NBITS  segment frame; bit NBITS-1 is shifted first.
- ready  output  1  high exactly when state=IDLE (registered-state decode).
- busy  output  1  high from cycle after accepted start until transfer completes.
- done  output  1  one-cycle pulse on completion.
- seg_clk  output  1  serial shift clock; chain samples seg_dat on rising edge.
- seg_dat  output  1  serial data.
- seg_pen  output  1  latch/parallel-enable strobe, high for DIV cycles after last bit.

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-transfer): state=IDLE, shreg=0, bit counter=0, div counter=0, ready=1, busy=0, done=0, seg_clk=0, seg_dat=0, seg_pen=0. A transfer aborted by reset produces no done and no seg_pen pulse.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - On start=1, capture shreg <= ACTIVE_LOW ? ~frame : frame.
  - Set seg_dat <= captured bit NBITS-1, busy<=1, div=0, bitcnt=0, then go to SHIFT_LO.
  - start while not in IDLE is ignored; no queueing.
- SHIFT_LO:
  - seg_clk=0 for DIV cycles; seg_dat stable.
  - After DIV cycles, go to SHIFT_HI.
- SHIFT_HI:
  - seg_clk=1 for DIV cycles.
  - After DIV cycles: if bitcnt=NBITS-1, go to LATCH (seg_clk<=0, seg_pen<=1).
  - Otherwise bitcnt++, shift shreg left, seg_dat<=next bit, and go to SHIFT_LO.
  - seg_dat changes only on the seg_clk falling transition, giving DIV cycles of setup and hold.
- LATCH:
  - seg_pen=1 for DIV cycles.
  - Then go to IDLE: seg_pen<=0, busy<=0, seg_dat<=0, done<=1 for exactly one cycle.
- Timing:
  - busy is high for exactly NBITS*2*DIV + DIV cycles (defaults: 258).
  - done coincides with the first IDLE cycle (ready=1, busy=0).
- Back-to-back: start asserted in the done cycle is accepted; the next frame begins with no gap cycle.
- frame may change freely after the accepting edge; only the captured copy is shifted.
- Counters:
  - div counter is 8 bits and wraps only via state transition, never free-running.
  - bitcnt is ceil(log2(NBITS)) bits and never exceeds NBITS-1.
- Outputs are registered, except ready, which is a decode of the state register. All outputs are glitch-free.

Test Plan:
- Reset/idle: hold rst 3 cycles, start=0 -> ready=1, busy=0, done=0, seg_clk=0, seg_dat=0, seg_pen=0 every cycle.
- Single frame, defaults (NBITS=64, DIV=2, ACTIVE_LOW=1), frame=64'h00FF_0000_0000_0001:
  - Bits captured on 64 seg_clk rising edges equal 64'hFF00_FFFF_FFFF_FFFE, MSB first.
  - busy high 258 cycles; seg_pen high 2 cycles; done one pulse.
- Minimum config (NBITS=8, DIV=1, ACTIVE_LOW=0), frame=8'hA5:
  - seg_dat sequence 1,0,1,0,0,1,0,1; seg_clk toggles every cycle; busy 17 cycles.
  - start held high through the transfer does not restart it.
- Back-to-back: assert start in the done cycle with frame=8'h3C (NBITS=8, DIV=1) -> busy rises next cycle, no idle gap; second stream is 0,0,1,1,1,1,0,0.
- Reset mid-operation: rst=1 after 20 serial bits (defaults) -> next cycle all outputs at reset values; no done or seg_pen pulse follows.
  - A fresh start then completes a full 258-cycle transfer.
- Input stability: change frame every cycle during a transfer -> shifted bits match only the value present at the accepting edge.
